muldiv_ctrl: RTL and testbench

//   Multi-cycle sequencer for signed MULT/DIV.

---
 rtl/muldiv_pkg.sv | 15 +
 rtl/muldiv_step.sv | 47 ++++
 rtl/muldiv_ctrl.sv | 133 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the MULT/DIV sequencer: operand width, op codes and FSM states.
package muldiv_pkg;

   localparam int MD_WIDTH = 32;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: a radix-2 Booth step for MULT,
// or a restoring-division step on magnitudes for DIV.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             op,
   input  logic [2*WIDTH:0] acc,
   input  logic [WIDTH:0]   operand,
   input  logic             booth_prev,
   output logic [2*WIDTH:0] acc_next,
   output logic             q_bit
);

   logic [WIDTH:0]   upper;
   logic [2*WIDTH:0] sum_acc;
   logic [2*WIDTH:0] shifted;
   logic [WIDTH:0]   diff;

   // Upper half is WIDTH+1 bits wide so that adding or subtracting the most
   // negative multiplicand never overflows before the arithmetic shift.
   always_comb begin
      upper    = acc[2*WIDTH:WIDTH];
      sum_acc  = acc;
      shifted  = '0;
      diff     = '0;
      acc_next = acc;
      q_bit    = 1'b0;
      if (op == OP_MULT) begin
         case ({acc[0], booth_prev})
            2'b01:   upper = upper + operand;
            2'b10:   upper = upper - operand;
            default: upper = acc[2*WIDTH:WIDTH];
         endcase
         sum_acc  = {upper, acc[WIDTH-1:0]};
         acc_next = {sum_acc[2*WIDTH], sum_acc[2*WIDTH:1]};
         q_bit    = acc[0];
      end else begin
         shifted  = {acc[2*WIDTH-1:0], 1'b0};
         diff     = shifted[2*WIDTH:WIDTH] - operand;
         q_bit    = ~diff[WIDTH];
         acc_next = q_bit ? {diff, shifted[WIDTH-1:1], 1'b1} : shifted;
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle signed MULT/DIV sequencer owning the architectural HI/LO registers.
// Runs WIDTH datapath steps per operation, then pulses done for one cycle.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH,
   parameter int CNT_W = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] low
);

   md_state_e        state;
   md_state_e        state_next;
   logic [CNT_W-1:0] cnt;
   logic [2*WIDTH:0] acc;
   logic [2*WIDTH:0] acc_next;
   logic [WIDTH:0]   operand;
   logic             booth_prev;
   logic             q_bit;
   logic             op_q;
   logic             neg_q;
   logic             neg_r;
   logic             accept;
   logic             div_by_zero;
   logic             last_step;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;

   assign accept      = (state == ST_IDLE) && start;
   assign div_by_zero = (op == OP_DIV) && (b == '0);
   assign last_step   = (state == ST_RUN) && (cnt == CNT_W'(WIDTH - 1));
   assign a_mag       = a[WIDTH-1] ? -a : a;
   assign b_mag       = b[WIDTH-1] ? -b : b;
   assign quo         = acc_next[WIDTH-1:0];
   assign rem         = acc_next[2*WIDTH-1:WIDTH];

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .op         (op_q),
      .acc        (acc),
      .operand    (operand),
      .booth_prev (booth_prev),
      .acc_next   (acc_next),
      .q_bit      (q_bit)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = div_by_zero ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (last_step) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != ST_IDLE);
      done = (state == ST_DONE);
   end

   // MULT keeps the raw signed operands (Booth handles signs); DIV works on
   // magnitudes and remembers which result halves need negating at the end.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt        <= '0;
         acc        <= '0;
         operand    <= '0;
         booth_prev <= 1'b0;
         op_q       <= OP_MULT;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         div_zero   <= 1'b0;
         hi         <= '0;
         low        <= '0;
      end else if (accept) begin
         op_q       <= op;
         cnt        <= '0;
         booth_prev <= 1'b0;
         div_zero   <= div_by_zero;
         neg_q      <= a[WIDTH-1] ^ b[WIDTH-1];
         neg_r      <= a[WIDTH-1];
         if (op == OP_MULT) begin
            acc     <= {(WIDTH+1)'(0), b};
            operand <= {a[WIDTH-1], a};
         end else begin
            acc     <= {(WIDTH+1)'(0), a_mag};
            operand <= {1'b0, b_mag};
         end
      end else if (state == ST_RUN) begin
         acc        <= acc_next;
         booth_prev <= q_bit;
         cnt        <= cnt + 1'b1;
         if (last_step) begin
            if (op_q == OP_MULT) begin
               hi  <= acc_next[2*WIDTH-1:WIDTH];
               low <= acc_next[WIDTH-1:0];
            end else begin
               hi  <= neg_r ? -rem : rem;
               low <= neg_q ? -quo : quo;
            end
         end
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: a cycle-countdown reference model with
// plain 64-bit arithmetic, a per-cycle compare process, and directed literal checks.
module tb_muldiv_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] low;

   int n_checks = 0;
   int n_fail   = 0;
   logic check_en = 1'b0;

   muldiv_ctrl dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .low      (low)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [63:0] ref_result(input logic o, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, q, r;
      logic [63:0] res, qv, rv;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (o == 1'b0) begin
         res = sx * sy;
      end else begin
         q   = sx / sy;
         r   = sx % sy;
         qv  = q;
         rv  = r;
         res = {rv[31:0], qv[31:0]};
      end
      return res;
   endfunction

   // Reference model: remaining = edges left until back in idle.
   int          remaining = 0;
   logic [63:0] pend      = '0;
   logic [31:0] m_hi      = '0;
   logic [31:0] m_low     = '0;
   logic        m_dz      = 1'b0;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         remaining = 0;
         pend      = '0;
         m_hi      = '0;
         m_low     = '0;
         m_dz      = 1'b0;
      end else if (remaining == 0) begin
         if (start) begin
            if (op && b == 32'd0) begin
               remaining = 1;
               m_dz      = 1'b1;
            end else begin
               remaining = 33;
               m_dz      = 1'b0;
               pend      = ref_result(op, a, b);
            end
         end
      end else begin
         remaining--;
         if (remaining == 1 && !m_dz) begin
            m_hi  = pend[63:32];
            m_low = pend[31:0];
         end
      end
   end

   always @(negedge clock) begin
      if (check_en) begin
         checkOutput("model busy", 64'(busy), 64'(remaining > 0));
         checkOutput("model done", 64'(done), 64'(remaining == 1));
         checkOutput("model div_zero", 64'(div_zero), 64'(m_dz));
         checkOutput("model hi", 64'(hi), 64'(m_hi));
         checkOutput("model low", 64'(low), 64'(m_low));
      end
   end

   // Issues one operation and waits for done; lat counts edges after the accepting edge.
   task automatic applyStimulus(input logic o, input logic [31:0] x, input logic [31:0] y, output int lat);
      @(negedge clock);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      op    = 1'($urandom);
      a     = $urandom;
      b     = $urandom;
      lat   = 0;
      while (!done && lat < 100) begin
         @(negedge clock);
         lat++;
      end
      if (!done) begin
         checkOutput("done timeout", 64'(done), 64'd1);
      end
      @(negedge clock);
      checkOutput("busy after done", 64'(busy), 64'd0);
      checkOutput("done is one pulse", 64'(done), 64'd0);
   endtask

   initial begin
      int lat;
      int dones;
      reset = 1'b1;
      start = 1'b0;
      op    = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(negedge clock);
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset done", 64'(done), 64'd0);
      checkOutput("reset hi", 64'(hi), 64'd0);
      checkOutput("reset low", 64'(low), 64'd0);
      checkOutput("reset div_zero", 64'(div_zero), 64'd0);
      reset    = 1'b0;
      check_en = 1'b1;

      $display("[TB] MULT 7 * -3");
      applyStimulus(1'b0, 32'd7, 32'hFFFFFFFD, lat);
      checkOutput("mult latency", 64'(lat), 64'd32);
      checkOutput("mult 7*-3 hi", 64'(hi), 64'hFFFFFFFF);
      checkOutput("mult 7*-3 low", 64'(low), 64'hFFFFFFEB);

      $display("[TB] MULT corner operands");
      applyStimulus(1'b0, 32'h80000000, 32'h80000000, lat);
      checkOutput("mult minneg hi", 64'(hi), 64'h40000000);
      checkOutput("mult minneg low", 64'(low), 64'h00000000);
      applyStimulus(1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, lat);
      checkOutput("mult maxpos hi", 64'(hi), 64'h3FFFFFFF);
      checkOutput("mult maxpos low", 64'(low), 64'h00000001);

      $display("[TB] DIV sign handling");
      applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2, lat);
      checkOutput("div latency", 64'(lat), 64'd32);
      checkOutput("div -7/2 low", 64'(low), 64'hFFFFFFFD);
      checkOutput("div -7/2 hi", 64'(hi), 64'hFFFFFFFF);
      applyStimulus(1'b1, 32'd7, 32'hFFFFFFFE, lat);
      checkOutput("div 7/-2 low", 64'(low), 64'hFFFFFFFD);
      checkOutput("div 7/-2 hi", 64'(hi), 64'h00000001);

      $display("[TB] DIV by zero");
      applyStimulus(1'b0, 32'd3, 32'd5, lat);
      applyStimulus(1'b1, 32'd5, 32'd0, lat);
      checkOutput("divzero latency", 64'(lat), 64'd0);
      checkOutput("divzero flag", 64'(div_zero), 64'd1);
      checkOutput("divzero hi kept", 64'(hi), 64'd0);
      checkOutput("divzero low kept", 64'(low), 64'd15);
      applyStimulus(1'b0, 32'd2, 32'd2, lat);
      checkOutput("divzero cleared", 64'(div_zero), 64'd0);

      $display("[TB] DIV overflow with ignored starts");
      @(negedge clock);
      op    = 1'b1;
      a     = 32'h80000000;
      b     = 32'hFFFFFFFF;
      start = 1'b1;
      @(negedge clock);
      op    = 1'b1;
      b     = 32'd0;
      dones = 0;
      for (int i = 0; i < 60; i++) begin
         if (done) dones++;
         start = (i == 5) || (i == 20) || done;
         @(negedge clock);
      end
      start = 1'b0;
      checkOutput("overflow done count", 64'(dones), 64'd1);
      checkOutput("overflow low", 64'(low), 64'h80000000);
      checkOutput("overflow hi", 64'(hi), 64'd0);

      $display("[TB] Reset mid-operation");
      @(negedge clock);
      op    = 1'b0;
      a     = 32'h12345678;
      b     = 32'h9ABCDEF1;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (9) @(negedge clock);
      #1 reset = 1'b1;
      #1;
      checkOutput("async reset busy", 64'(busy), 64'd0);
      checkOutput("async reset done", 64'(done), 64'd0);
      checkOutput("async reset hi", 64'(hi), 64'd0);
      checkOutput("async reset low", 64'(low), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      applyStimulus(1'b0, 32'd2, 32'd3, lat);
      checkOutput("post reset hi", 64'(hi), 64'd0);
      checkOutput("post reset low", 64'(low), 64'd6);

      $display("[TB] Randomized operations");
      for (int n = 0; n < 24; n++) begin
         logic        ro;
         logic [31:0] ra;
         logic [31:0] rb;
         ro = 1'($urandom);
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: ra = 32'h80000000;
            1: rb = 32'hFFFFFFFF;
            2: rb = ro ? 32'd0 : rb;
            3: rb = 32'($urandom_range(1, 9));
            default: ;
         endcase
         applyStimulus(ro, ra, rb, lat);
         repeat ($urandom_range(0, 3)) @(negedge clock);
      end

      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
